// File: rtl/line_tool_pkg.sv
// Shared definitions for the line tool: color encoding and small helpers.
package line_tool_pkg;

    localparam int COLOR_WIDTH = 4;
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = '0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_tool.sv
// Press-drag-release line tool: latches two endpoints and rasterises the line with Bresenham.
// Optional macro LINE_TOOL_ANCHOR_MARK_EN marks the anchor pixel immediately on press.
module line_tool
    import line_tool_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [$clog2(WIDTH)-1:0]    cursor_x,
    input  logic [$clog2(HEIGHT)-1:0]   cursor_y,
    input  logic [COLOR_WIDTH-1:0]      input_color,
    output logic [$clog2(WIDTH)-1:0]    pixel_x,
    output logic [$clog2(HEIGHT)-1:0]   pixel_y,
    output logic [COLOR_WIDTH-1:0]      pixel_color,
    output logic                        busy
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SW = max_int(XW, YW) + 2;

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SETUP,
        DRAW
    } state_t;

    state_t                   state_q;
    logic                     enable_q;
    logic [XW-1:0]            x0_q, x1_q, cur_x_q;
    logic [YW-1:0]            y0_q, y1_q, cur_y_q;
    logic [COLOR_WIDTH-1:0]   color_q, pix_color_q;
    logic                     busy_q;
    logic signed [SW-1:0]     dx_q, dy_q, err_q;
    logic                     x_neg_q, y_neg_q;

    logic                     press, release_ev, at_end;
    logic [XW-1:0]            cx_clamp, cur_x_d;
    logic [YW-1:0]            cy_clamp, cur_y_d;
    logic signed [SW-1:0]     diff_x, diff_y, dx_d, dy_d, err_setup, e2, err_d;
    logic                     step_x, step_y;

    assign press      = enable & ~enable_q;
    assign release_ev = ~enable & enable_q;
    assign cx_clamp   = (cursor_x > X_MAX) ? X_MAX : cursor_x;
    assign cy_clamp   = (cursor_y > Y_MAX) ? Y_MAX : cursor_y;
    assign at_end     = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    // Setup terms: dx positive, dy stored negated so err = dx + dy.
    always_comb begin
        diff_x    = SW'(x1_q) - SW'(x0_q);
        diff_y    = SW'(y1_q) - SW'(y0_q);
        dx_d      = (diff_x < 0) ? -diff_x : diff_x;
        dy_d      = (diff_y < 0) ? diff_y : -diff_y;
        err_setup = dx_d + dy_d;
    end

    // Both step decisions use the error from the start of the cycle.
    always_comb begin
        e2      = err_q <<< 1;
        step_x  = (e2 >= dy_q);
        step_y  = (e2 <= dx_q);
        err_d   = err_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step_x) begin
            err_d   = err_d + dy_q;
            cur_x_d = x_neg_q ? (cur_x_q - X_ONE) : (cur_x_q + X_ONE);
        end
        if (step_y) begin
            err_d   = err_d + dx_q;
            cur_y_d = y_neg_q ? (cur_y_q - Y_ONE) : (cur_y_q + Y_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            color_q     <= COLOR_NONE;
            pix_color_q <= COLOR_NONE;
            busy_q      <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            x_neg_q     <= 1'b0;
            y_neg_q     <= 1'b0;
        end else begin
            enable_q <= enable;
            case (state_q)
                IDLE: begin
                    pix_color_q <= COLOR_NONE;
                    busy_q      <= 1'b0;
                    if (press) begin
                        x0_q    <= cx_clamp;
                        y0_q    <= cy_clamp;
                        state_q <= ARMED;
`ifdef LINE_TOOL_ANCHOR_MARK_EN
                        cur_x_q     <= cx_clamp;
                        cur_y_q     <= cy_clamp;
                        pix_color_q <= input_color;
`endif
                    end
                end
                ARMED: begin
                    pix_color_q <= COLOR_NONE;
                    if (release_ev) begin
                        x1_q    <= cx_clamp;
                        y1_q    <= cy_clamp;
                        color_q <= input_color;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q        <= dx_d;
                    dy_q        <= dy_d;
                    err_q       <= err_setup;
                    x_neg_q     <= (diff_x < 0);
                    y_neg_q     <= (diff_y < 0);
                    cur_x_q     <= x0_q;
                    cur_y_q     <= y0_q;
                    pix_color_q <= color_q;
                    state_q     <= DRAW;
                end
                DRAW: begin
                    if (at_end) begin
                        pix_color_q <= COLOR_NONE;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                        err_q   <= err_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_x     = cur_x_q;
    assign pixel_y     = cur_y_q;
    assign pixel_color = pix_color_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_line_tool.sv
// Self-checking bench for line_tool: directed lines, random lines against a point-list model,
// reset abort, ignored presses and the LINE_TOOL_ANCHOR_MARK_EN behaviour.
module tb_line_tool;
    import line_tool_pkg::*;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [XW-1:0]          cursor_x;
    logic [YW-1:0]          cursor_y;
    logic [COLOR_WIDTH-1:0] input_color;
    logic [XW-1:0]          pixel_x;
    logic [YW-1:0]          pixel_y;
    logic [COLOR_WIDTH-1:0] pixel_color;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];

    line_tool #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .input_color(input_color),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference point list for a line, endpoints clamped to the canvas.
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int x0, y0, x1, y1, dx, dy, sx, sy, err, e2;
        x0 = (ax > W - 1) ? W - 1 : ax;
        y0 = (ay > H - 1) ? H - 1 : ay;
        x1 = (bx > W - 1) ? W - 1 : bx;
        y1 = (by > H - 1) ? H - 1 : by;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        exp_x.delete();
        exp_y.delete();
        while (1) begin
            exp_x.push_back(x0);
            exp_y.push_back(y0);
            if (x0 == x1 && y0 == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x0 += sx; end
            if (e2 <= dx) begin err += dx; y0 += sy; end
        end
    endtask

    // Draws one line; optional press/release pokes at given DRAW cycle indices.
    task automatic run_line(input string name, input int ax, input int ay, input int bx,
                            input int by, input logic [COLOR_WIDTH-1:0] col,
                            input int poke_press, input int poke_release);
        model_line(ax, ay, bx, by);
        @(negedge clk);
        enable = 1'b1; cursor_x = XW'(ax); cursor_y = YW'(ay);
        @(negedge clk);
        enable = 1'b0; cursor_x = XW'(bx); cursor_y = YW'(by); input_color = col;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pixel_color !== COLOR_NONE) begin
            errors++;
            $display("FAIL %s setup: busy=%b color=%h, required busy=1 color=%h",
                     name, busy, pixel_color, COLOR_NONE);
        end
        input_color = ~col;
        for (int i = 0; i < exp_x.size(); i++) begin
            @(negedge clk);
            checks++;
            if (pixel_color !== col || busy !== 1'b1 ||
                int'(pixel_x) != exp_x[i] || int'(pixel_y) != exp_y[i]) begin
                errors++;
                $display("FAIL %s pixel %0d: got (%0d,%0d) color=%h busy=%b, required (%0d,%0d) color=%h busy=1",
                         name, i, pixel_x, pixel_y, pixel_color, busy, exp_x[i], exp_y[i], col);
            end
            if (i == poke_press) begin
                enable = 1'b1; cursor_x = XW'(300); cursor_y = YW'(300);
            end
            if (i == poke_release) enable = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (pixel_color !== COLOR_NONE || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after end: color=%h busy=%b, required color=%h busy=0",
                     name, pixel_color, busy, COLOR_NONE);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pixel_color !== COLOR_NONE || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d active cycles, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cursor_x = '0; cursor_y = '0; input_color = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pixel_x !== '0 || pixel_y !== '0 || pixel_color !== COLOR_NONE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset state: x=%0d y=%0d color=%h busy=%b, required 0 0 %h 0",
                     pixel_x, pixel_y, pixel_color, busy, COLOR_NONE);
        end
    endtask

    task automatic test_directed();
        run_line("horizontal", 10, 20, 14, 20, 4'h3, -1, -1);
        run_line("reverse",    14, 20, 10, 20, 4'h5, -1, -1);
        run_line("steep",       5,  5,  6,  9, 4'h7, -1, -1);
        run_line("diagonal",    0,  0,  3,  3, 4'h1, -1, -1);
        run_line("zero_len",    7,  7,  7,  7, 4'hA, -1, -1);
        run_line("vert_up",    50, 40, 50, 30, 4'h2, -1, -1);
        run_line("oct_back",   60, 60, 40, 52, 4'hC, -1, -1);
    endtask

    task automatic test_clamp();
        run_line("clamp", 630, 470, 1000, 500, 4'h6, -1, -1);
    endtask

    task automatic test_random();
        int ax, ay, bx, by;
        for (int n = 0; n < 25; n++) begin
            ax = (n % 5 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, W - 1);
            ay = (n % 5 == 0) ? $urandom_range(0, 511)  : $urandom_range(0, H - 1);
            bx = $urandom_range(0, W - 1);
            by = $urandom_range(0, H - 1);
            run_line("random", ax, ay, bx, by, 4'($urandom_range(1, 15)), -1, -1);
        end
    endtask

    task automatic test_reset_mid_draw();
        @(negedge clk);
        enable = 1'b1; cursor_x = '0; cursor_y = '0;
        @(negedge clk);
        enable = 1'b0; cursor_x = XW'(100); input_color = 4'h9;
        repeat (4) @(negedge clk);
        checks++;
        if (pixel_x !== XW'(2) || pixel_color !== 4'h9) begin
            errors++;
            $display("FAIL reset_mid third pixel: x=%0d color=%h, required x=2 color=9",
                     pixel_x, pixel_color);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (pixel_color !== COLOR_NONE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid abort: color=%h busy=%b, required %h 0",
                     pixel_color, busy, COLOR_NONE);
        end
        expect_quiet("reset_mid", 10);
    endtask

    task automatic test_ignored_press();
        run_line("press_in_draw", 0, 0, 20, 0, 4'h4, 5, 8);
        expect_quiet("press_in_draw", 30);
        run_line("held_past_draw", 0, 10, 12, 10, 4'hB, 4, 100);
        expect_quiet("held_past_draw", 10);
        enable = 1'b0;
        expect_quiet("release_after_draw", 10);
    endtask

    task automatic test_anchor_mark();
        @(negedge clk);
        enable = 1'b1; cursor_x = XW'(3); cursor_y = YW'(4); input_color = 4'hD;
        @(negedge clk);
        checks++;
`ifdef LINE_TOOL_ANCHOR_MARK_EN
        if (pixel_color !== 4'hD || pixel_x !== XW'(3) || pixel_y !== YW'(4)) begin
            errors++;
            $display("FAIL anchor_mark: got (%0d,%0d) color=%h, required (3,4) color=d",
                     pixel_x, pixel_y, pixel_color);
        end
`else
        if (pixel_color !== COLOR_NONE || busy !== 1'b0) begin
            errors++;
            $display("FAIL anchor_mark off: color=%h busy=%b, required %h 0",
                     pixel_color, busy, COLOR_NONE);
        end
`endif
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pixel_color !== 4'hD || pixel_x !== XW'(3) || pixel_y !== YW'(4)) begin
            errors++;
            $display("FAIL anchor_mark line: got (%0d,%0d) color=%h, required (3,4) color=d",
                     pixel_x, pixel_y, pixel_color);
        end
        expect_quiet("anchor_mark", 5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clamp();
        test_reset_mid_draw();
        test_ignored_press();
        test_anchor_mark();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
